eth_rx_slot_ctrl: RTL and testbench

ETH_RX_SLOT_CTRL -- requirements
Module: eth_rx_slot_ctrl

---
 rtl/eth_rx_slot_ctrl_if.sv | 49 ++++
 rtl/eth_rx_slot_ctrl.sv | 176 +++++++++++++++++
 tb/tb_eth_rx_slot_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_slot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_slot_ctrl_if
//  Description : Receive byte stream, buffer RAM write port and host slot
//                status bundle for eth_rx_slot_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_rx_slot_ctrl_if #(
    parameter int NSLOT      = 4,
    parameter int SLOT_BYTES = 2048
);
    localparam int IW = $clog2(NSLOT);
    localparam int AW = IW + $clog2(SLOT_BYTES);
    localparam int CW = IW + 1;

    // receive stream
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_last;
    logic          rx_err;
    // buffer RAM write port
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    // host side
    logic          pop;
    logic [IW-1:0] head_idx;
    logic [15:0]   head_len;
    logic [CW-1:0] count;
    logic          frame_avail;
    logic          irq_en;
    logic          irq;
    logic [15:0]   drop_cnt;

    // slot controller view
    modport slave (
        input  rx_valid, rx_data, rx_last, rx_err, pop, irq_en,
        output mem_we, mem_waddr, mem_wdata, head_idx, head_len,
               count, frame_avail, irq, drop_cnt
    );

    // MAC / host view
    modport master (
        output rx_valid, rx_data, rx_last, rx_err, pop, irq_en,
        input  mem_we, mem_waddr, mem_wdata, head_idx, head_len,
               count, frame_avail, irq, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/eth_rx_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_slot_ctrl
//  Description : Ethernet receive slot ring controller. Writes incoming frame
//                bytes into fixed-size RAM slots, commits good frames into a
//                ring of NSLOT slots and counts dropped frames.
//                Optional macro ETH_RXSLOT_FCS_STRIP_EN: strip the 4-byte FCS
//                from the committed length and drop frames of <= 4 bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_slot_ctrl #(
    parameter int NSLOT      = 4,
    parameter int SLOT_BYTES = 2048
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    eth_rx_slot_ctrl_if.slave   bus
);
    localparam int c_IW = $clog2(NSLOT);
    localparam int c_OW = $clog2(SLOT_BYTES) + 1;   // offset reaches SLOT_BYTES
    localparam int c_AW = c_IW + c_OW - 1;
    localparam int c_CW = c_IW + 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(NSLOT);
    localparam logic [c_OW-1:0] c_OVERSIZE = c_OW'(SLOT_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_wr_ptr;
    logic [c_IW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_OW-1:0]   r_offset;
    logic [15:0]       r_drop_cnt;
    logic              r_mem_we;
    logic [c_AW-1:0]   r_mem_waddr;
    logic [7:0]        r_mem_wdata;
    logic [15:0]       r_len [NSLOT];

    state_t            w_state_nxt;
    logic [c_OW-1:0]   w_offset_nxt;
    logic              w_wr_en;
    logic [c_OW-2:0]   w_wr_off;
    logic              w_fin;        // last byte of an in-slot frame accepted
    logic [c_OW-1:0]   w_total;
    logic              w_short;
    logic              w_commit;
    logic              w_drop_inc;
    logic [15:0]       w_len;
    logic              w_pop;

    // next-state, byte acceptance, commit and drop decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_wr_en      = 1'b0;
        w_wr_off     = '0;
        w_fin        = 1'b0;
        w_total      = '0;
        w_short      = 1'b0;
        w_commit     = 1'b0;
        w_drop_inc   = 1'b0;
        w_len        = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (r_count == c_FULL) begin
                        // ring full: no slot to start into
                        if (bus.rx_last) w_drop_inc  = 1'b1;
                        else             w_state_nxt = S_DROP;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_offset_nxt = c_OW'(1);
                        if (bus.rx_last) begin
                            w_fin   = 1'b1;
                            w_total = c_OW'(1);
                        end else begin
                            w_state_nxt = S_RECV;
                        end
                    end
                end
            end
            S_RECV: begin
                if (bus.rx_valid) begin
                    if (r_offset == c_OVERSIZE) begin
                        // slot already full: frame is oversize
                        if (bus.rx_last) begin
                            w_drop_inc  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DROP;
                        end
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_off     = r_offset[c_OW-2:0];
                        w_offset_nxt = r_offset + c_OW'(1);
                        if (bus.rx_last) begin
                            w_fin       = 1'b1;
                            w_total     = r_offset + c_OW'(1);
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_DROP: begin
                if (bus.rx_valid && bus.rx_last) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef ETH_RXSLOT_FCS_STRIP_EN
        w_short = (w_total <= c_OW'(4));
        w_len   = 16'(w_total) - 16'd4;
`else
        w_short = 1'b0;
        w_len   = 16'(w_total);
`endif
        w_commit = w_fin & ~bus.rx_err & ~w_short;
        if (w_fin && !w_commit) w_drop_inc = 1'b1;
    end

    // an empty ring ignores pop
    assign w_pop = bus.pop && (r_count != '0);

    // FSM, ring pointers, occupancy, drop counter and RAM write register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_offset    <= '0;
            r_drop_cnt  <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_mem_we <= w_wr_en;
            if (w_wr_en) begin
                r_mem_waddr <= {r_wr_ptr, w_wr_off};
                r_mem_wdata <= bus.rx_data;
            end
            if (w_commit) r_wr_ptr <= r_wr_ptr + c_IW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_IW'(1);
            // simultaneous commit and pop leaves occupancy unchanged
            if (w_commit && !w_pop)      r_count <= r_count + c_CW'(1);
            else if (!w_commit && w_pop) r_count <= r_count - c_CW'(1);
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // committed slot lengths; only read back while the slot is occupied
    always_ff @(posedge clk) begin
        if (w_commit) r_len[r_wr_ptr] <= w_len;
    end

    assign bus.mem_we      = r_mem_we;
    assign bus.mem_waddr   = r_mem_waddr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.head_idx    = r_rd_ptr;
    assign bus.head_len    = r_len[r_rd_ptr];
    assign bus.count       = r_count;
    assign bus.frame_avail = (r_count != '0);
    assign bus.irq         = bus.irq_en & (r_count != '0);
    assign bus.drop_cnt    = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_eth_rx_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_slot_ctrl
//  Description : Directed self-checking bench for eth_rx_slot_ctrl
//                (NSLOT=4, SLOT_BYTES=2048).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_slot_ctrl;
    localparam int NSLOT      = 4;
    localparam int SLOT_BYTES = 2048;
    localparam logic [7:0] c_SEED = 8'hA5;

`ifdef ETH_RXSLOT_FCS_STRIP_EN
    localparam int c_FCS = 4;
`else
    localparam int c_FCS = 0;
`endif

    logic clk;
    logic rst_n;

    eth_rx_slot_ctrl_if #(.NSLOT(NSLOT), .SLOT_BYTES(SLOT_BYTES)) bus ();

    eth_rx_slot_ctrl #(.NSLOT(NSLOT), .SLOT_BYTES(SLOT_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total;
    int n_pass;

    // write monitor state
    int wr_cnt;
    int addr_err;
    int data_err;
    int exp_base;
    bit mon_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // counts RAM writes and checks address/data sequence within one frame
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (mon_chk) begin
                if (int'(bus.mem_waddr) != exp_base + wr_cnt) addr_err++;
                if (bus.mem_wdata != 8'(c_SEED + 8'(wr_cnt))) data_err++;
            end
            wr_cnt++;
        end
    end

    task automatic start_mon(input int base, input bit en);
        wr_cnt   = 0;
        addr_err = 0;
        data_err = 0;
        exp_base = base;
        mon_chk  = en;
    endtask

    // drives n bytes; final byte carries rx_last when term is set
    task automatic send_frame(input int n, input bit err, input bit pop_last, input bit term);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(c_SEED + 8'(i));
            bus.rx_last  = term && (i == n - 1);
            bus.rx_err   = err && term && (i == n - 1);
            bus.pop      = pop_last && (i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        bus.rx_err   = 1'b0;
        bus.pop      = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_pop();
        @(negedge clk);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        start_mon(0, 1'b0);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_last  = 1'b0;
        bus.rx_err   = 1'b0;
        bus.pop      = 1'b0;
        bus.irq_en   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_count",    32'(bus.count), 0);
        chk("rst_avail",    32'(bus.frame_avail), 0);
        chk("rst_irq",      32'(bus.irq), 0);
        chk("rst_drop",     32'(bus.drop_cnt), 0);
        chk("rst_we",       32'(bus.mem_we), 0);

        // 60-byte frame into slot 0
        start_mon(0, 1'b1);
        send_frame(60, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("f60_writes",   32'(wr_cnt), 60);
        chk("f60_addr",     32'(addr_err), 0);
        chk("f60_data",     32'(data_err), 0);
        chk("f60_count",    32'(bus.count), 1);
        chk("f60_head_idx", 32'(bus.head_idx), 0);
        chk("f60_head_len", 32'(bus.head_len), 60 - c_FCS);
        chk("f60_irq",      32'(bus.irq), 1);
        bus.irq_en = 1'b0;
        @(negedge clk);
        chk("irq_masked",   32'(bus.irq), 0);
        bus.irq_en = 1'b1;

        // release slot 0, then pop on an empty ring
        do_pop();
        chk("pop_count",    32'(bus.count), 0);
        chk("pop_irq",      32'(bus.irq), 0);
        do_pop();
        chk("pop0_count",   32'(bus.count), 0);
        chk("pop0_head",    32'(bus.head_idx), 1);

        // five back-to-back 64-byte frames: slots 1,2,3,0 fill, fifth dropped
        start_mon(0, 1'b0);
        for (int f = 0; f < 5; f++) send_frame(64, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("full_writes",  32'(wr_cnt), 256);
        chk("full_count",   32'(bus.count), 4);
        chk("full_drop",    32'(bus.drop_cnt), 1);
        chk("full_head",    32'(bus.head_idx), 1);
        chk("full_len",     32'(bus.head_len), 64 - c_FCS);

        // two pops -> count 2, head slot 3; then commit to slot 1 with pop
        do_pop();
        do_pop();
        chk("pop2_count",   32'(bus.count), 2);
        chk("pop2_head",    32'(bus.head_idx), 3);
        send_frame(20, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("cp_count",     32'(bus.count), 2);
        chk("cp_head",      32'(bus.head_idx), 0);
        chk("cp_len",       32'(bus.head_len), 64 - c_FCS);

        // errored frame into slot 2 region: written but not committed
        start_mon(2 * SLOT_BYTES, 1'b1);
        send_frame(10, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("err_writes",   32'(wr_cnt), 10);
        chk("err_addr",     32'(addr_err), 0);
        chk("err_count",    32'(bus.count), 2);
        chk("err_drop",     32'(bus.drop_cnt), 2);

        // oversize frame: 2048 bytes written, 2049th discarded
        start_mon(2 * SLOT_BYTES, 1'b1);
        send_frame(SLOT_BYTES + 1, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("big_writes",   32'(wr_cnt), SLOT_BYTES);
        chk("big_addr",     32'(addr_err), 0);
        chk("big_data",     32'(data_err), 0);
        chk("big_count",    32'(bus.count), 2);
        chk("big_drop",     32'(bus.drop_cnt), 3);

        // single-byte frame: commits unless FCS stripping is enabled
        send_frame(1, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("one_count",    32'(bus.count), (c_FCS != 0) ? 2 : 3);
        chk("one_drop",     32'(bus.drop_cnt), (c_FCS != 0) ? 4 : 3);

        // reset after byte 30 of a frame
        send_frame(30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_count",   32'(bus.count), 0);
        chk("mrst_drop",    32'(bus.drop_cnt), 0);
        chk("mrst_we",      32'(bus.mem_we), 0);
        chk("mrst_waddr",   32'(bus.mem_waddr), 0);
        chk("mrst_wdata",   32'(bus.mem_wdata), 0);
        chk("mrst_irq",     32'(bus.irq), 0);
        chk("mrst_head",    32'(bus.head_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_mon(0, 1'b1);
        send_frame(64, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("post_writes",  32'(wr_cnt), 64);
        chk("post_addr",    32'(addr_err), 0);
        chk("post_count",   32'(bus.count), 1);
        chk("post_head",    32'(bus.head_idx), 0);
        chk("post_len",     32'(bus.head_len), 64 - c_FCS);
        chk("post_drop",    32'(bus.drop_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
